demux_1to2_64: RTL and testbench

DEMUX_1TO2_64 -- requirements
Module: demux_1to2_64

---
 rtl/demux_1to2_64.sv | 124 ++++++++++++
 tb/tb_demux_1to2_64.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_64.sv
// ---------------------------------------------------------------------------
// demux_1to2_64
//   Routes a valid/ready input stream to one of two output channels (A or B),
//   selected per word by in_sel. Each channel owns an independent 2-entry FIFO,
//   so a stalled consumer on one channel never blocks traffic to the other.
//
// Ports
//   clk, rst_n          : clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data is the word, in_sel the
//                         destination (0 = A, 1 = B)
//   a_valid/a_ready/a_data : channel A output handshake and head word
//   b_valid/b_ready/b_data : channel B output handshake and head word
//   a_level, b_level    : per-channel buffer occupancy, 0..2
// ---------------------------------------------------------------------------
module demux_1to2_64 #(
  parameter int k = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [k-1:0] in_data,
  input  logic         in_sel,
  output logic         a_valid,
  input  logic         a_ready,
  output logic [k-1:0] a_data,
  output logic         b_valid,
  input  logic         b_ready,
  output logic [k-1:0] b_data,
  output logic [1:0]   a_level,
  output logic [1:0]   b_level
);

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0]   hit_s;
  logic [1:0]   cons_ready_s;
  logic [1:0]   level_s [2];
  logic [k-1:0] head_s  [2];

  assign hit_s        = {in_sel, ~in_sel};
  assign cons_ready_s = {b_ready, a_ready};

  // Acceptance looks only at the selected channel's registered occupancy, so
  // there is no path from a_ready/b_ready to in_ready. A full channel refuses
  // even when it pops in the same cycle.
  assign in_ready = in_sel ? (level_s[1] != 2'd2) : (level_s[0] != 2'd2);

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [1:0]   lvl_q, lvl_d;
    logic [k-1:0] e0_q, e0_d;   // head entry
    logic [k-1:0] e1_q, e1_d;   // second entry, only meaningful at level 2
    logic         push_s;
    logic         pop_s;

    // Next-state of the 2-entry FIFO: entry 0 is always the head.
    always_comb begin
      push_s = in_valid & in_ready & hit_s[ch];
      pop_s  = (lvl_q != 2'd0) & cons_ready_s[ch];
      lvl_d  = lvl_q;
      e0_d   = e0_q;
      e1_d   = e1_q;
      case (lvl_q)
        2'd0: begin
          if (push_s) begin
            e0_d  = in_data;
            lvl_d = 2'd1;
          end else begin
            lvl_d = 2'd0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            // Old head leaves, new word becomes head; level stays at 1.
            e0_d  = in_data;
            lvl_d = 2'd1;
          end else if (push_s) begin
            e1_d  = in_data;
            lvl_d = 2'd2;
          end else if (pop_s) begin
            lvl_d = 2'd0;
          end else begin
            lvl_d = 2'd1;
          end
        end
        2'd2: begin
          // push_s cannot be set here because in_ready is low for this channel.
          if (pop_s) begin
            e0_d  = e1_q;
            lvl_d = 2'd1;
          end else begin
            lvl_d = 2'd2;
          end
        end
        default: begin
          lvl_d = 2'd0;
        end
      endcase
    end

    // FIFO state registers; reset empties the buffer asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl_q <= 2'd0;
        e0_q  <= {k{1'b0}};
        e1_q  <= {k{1'b0}};
      end else begin
        lvl_q <= lvl_d;
        e0_q  <= e0_d;
        e1_q  <= e1_d;
      end
    end

    assign level_s[ch] = lvl_q;
    assign head_s[ch]  = e0_q;
  end

  assign a_valid = (level_s[0] != 2'd0);
  assign a_data  = head_s[0];
  assign a_level = level_s[0];
  assign b_valid = (level_s[1] != 2'd0);
  assign b_data  = head_s[1];
  assign b_level = level_s[1];

endmodule

// File: tb/tb_demux_1to2_64.sv
module tb_demux_1to2_64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_sel;
  logic        a_valid;
  logic        a_ready;
  logic [63:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [63:0] b_data;
  logic [1:0]  a_level;
  logic [1:0]  b_level;

  int total = 0;
  int bad   = 0;
  int a_pops = 0;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];

  typedef struct {
    logic        iv;
    logic        is;
    logic [63:0] id;
    logic        ar;
    logic        br;
    logic        e_rdy;
    logic        e_av;
    logic [63:0] e_ad;
    logic [1:0]  e_al;
    logic        e_bv;
    logic [63:0] e_bd;
    logic [1:0]  e_bl;
  } vec_t;

  vec_t vec [10];

  demux_1to2_64 #(.k(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_level(a_level), .b_level(b_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset throws away everything the scoreboard expected.
  always @(negedge rst_n) begin
    q_a.delete();
    q_b.delete();
  end

  // Scoreboard: at the falling edge the handshakes for the next rising edge
  // are settled, so pops are checked against the queue heads and pushes queued.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_valid_model", {63'd0, a_valid}, {63'd0, q_a.size() != 0});
      chk("b_valid_model", {63'd0, b_valid}, {63'd0, q_b.size() != 0});
      chk("a_level_model", {62'd0, a_level}, 64'(q_a.size()));
      chk("b_level_model", {62'd0, b_level}, 64'(q_b.size()));
      if (a_valid && a_ready) begin
        a_pops++;
        if (q_a.size() == 0) chk("a_spurious", a_data, 64'hDEAD_DEAD_DEAD_DEAD);
        else chk("a_order", a_data, q_a.pop_front());
      end
      if (b_valid && b_ready) begin
        if (q_b.size() == 0) chk("b_spurious", b_data, 64'hDEAD_DEAD_DEAD_DEAD);
        else chk("b_order", b_data, q_b.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sel) q_b.push_back(in_data);
        else q_a.push_back(in_data);
      end
    end
  end

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, "_a_valid"}, {63'd0, a_valid}, {63'd0, v.e_av});
    chk({tag, "_a_level"}, {62'd0, a_level}, {62'd0, v.e_al});
    chk({tag, "_b_valid"}, {63'd0, b_valid}, {63'd0, v.e_bv});
    chk({tag, "_b_level"}, {62'd0, b_level}, {62'd0, v.e_bl});
    if (v.e_av) chk({tag, "_a_data"}, a_data, v.e_ad);
    if (v.e_bv) chk({tag, "_b_data"}, b_data, v.e_bd);
  endtask

  initial begin
    int start_pops;

    // iv is id ar br | rdy | av ad al | bv bd bl  (outputs after the edge)
    vec[0] = '{1'b1, 1'b0, 64'h1111, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1111, 2'd1, 1'b0, 64'h0, 2'd0};
    vec[1] = '{1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    2'd0, 1'b0, 64'h0, 2'd0};
    vec[2] = '{1'b1, 1'b0, 64'hA1,   1'b0, 1'b0, 1'b1, 1'b1, 64'hA1,   2'd1, 1'b0, 64'h0, 2'd0};
    vec[3] = '{1'b1, 1'b0, 64'hA2,   1'b0, 1'b0, 1'b1, 1'b1, 64'hA1,   2'd2, 1'b0, 64'h0, 2'd0};
    vec[4] = '{1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b1, 64'hA1,   2'd2, 1'b0, 64'h0, 2'd0};
    vec[5] = '{1'b0, 1'b1, 64'h0,    1'b0, 1'b0, 1'b1, 1'b1, 64'hA1,   2'd2, 1'b0, 64'h0, 2'd0};
    vec[6] = '{1'b1, 1'b1, 64'hB1,   1'b0, 1'b0, 1'b1, 1'b1, 64'hA1,   2'd2, 1'b1, 64'hB1, 2'd1};
    // Full channel A pops while a push is offered: the push must be refused.
    vec[7] = '{1'b1, 1'b0, 64'hA3,   1'b1, 1'b0, 1'b0, 1'b1, 64'hA2,   2'd1, 1'b1, 64'hB1, 2'd1};
    vec[8] = '{1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    2'd0, 1'b1, 64'hB1, 2'd1};
    vec[9] = '{1'b0, 1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 1'b0, 64'h0,    2'd0, 1'b0, 64'h0, 2'd0};

    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = 64'd0;
    a_ready = 1'b0; b_ready = 1'b0;
    step(); step();
    chk("rst_a_level", {62'd0, a_level}, 64'd0);
    chk("rst_b_level", {62'd0, b_level}, 64'd0);
    chk("rst_a_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Routing, fill/backpressure, isolation and ordering vectors.
    for (int i = 0; i < 10; i++) begin
      in_valid = vec[i].iv; in_sel = vec[i].is; in_data = vec[i].id;
      a_ready = vec[i].ar; b_ready = vec[i].br;
      #1;
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vec[i].e_rdy});
      @(posedge clk); #1;
      chk_out($sformatf("v%0d", i), vec[i]);
    end
    in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    step();

    // Streaming 0..99 into A with the consumer always ready.
    start_pops = a_pops;
    a_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'(i);
      #1;
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      chk("stream_level_lt2", {63'd0, a_level != 2'd2}, 64'd1);
    end
    in_valid = 1'b0;
    step(); step();
    chk("stream_count", 64'(a_pops - start_pops), 64'd100);
    chk("stream_drained", {62'd0, a_level}, 64'd0);
    a_ready = 1'b0;

    // Simultaneous push and pop at level 1.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hC1;
    step();
    chk("c1_head", a_data, 64'hC1);
    in_data = 64'hC2; a_ready = 1'b1;
    step();
    chk("pushpop_level", {62'd0, a_level}, 64'd1);
    chk("pushpop_head", a_data, 64'hC2);
    in_valid = 1'b0;
    step();
    a_ready = 1'b0;

    // Reset mid-flight with A=2, B=1.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hD1; step();
    in_data = 64'hD2; step();
    in_sel = 1'b1; in_data = 64'hE1; step();
    in_valid = 1'b0;
    chk("pre_rst_a_level", {62'd0, a_level}, 64'd2);
    chk("pre_rst_b_level", {62'd0, b_level}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_level", {62'd0, a_level}, 64'd0);
    chk("mid_rst_b_level", {62'd0, b_level}, 64'd0);
    chk("mid_rst_valids", {62'd0, a_valid, b_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    #1;
    rst_n = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1;
    step();
    chk("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale", {62'd0, a_valid, b_valid}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
